wrr_burst_arbiter: RTL and testbench
====================================

Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource among N requesters.
- Each grant is held for a burst of up to weight[i] accepted beats, then moves on to the next requester.
- Sits between the request sources and the shared resource.
- Gives the plain round-robin arbiter burst/quota control and a ready handshake with the resource.

Parameters:
- N, 4, number of requesters (2..16)
- WGT_W, 4, width of each per-requester weight field
- ID_W, $clog2(N), width of grant_id

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req  input  N  request per requester; level, held until served or withdrawn
- weight  input  N*WGT_W  per-requester burst quota; field i is weight[i*WGT_W +: WGT_W]
- res_ready  input  1  resource accepts a beat this cycle
- gnt  output  N  one-hot grant, registered
- gnt_valid  output  1  a grant is active, registered
- grant_id  output  ID_W  binary index of the granted requester, 0 when idle
- beat_cnt  output  WGT_W  beats accepted in the current burst

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, gnt_valid=0, grant_id=0, beat_cnt=0.
  - Pointer ptr=0, so requester 0 has top priority first.
  - State IDLE.
- Eligibility:
  - elig[i] = req[i] && (weight field i != 0).
  - Weight 0 masks a requester; it is never granted.
- Pick function:
  - Takes the lowest-index eligible requester at or after ptr, searching circularly (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- Beat:
  - A beat is gnt_valid && res_ready in the same cycle.
- State IDLE:
  - Outputs are at reset values.
  - If any elig: register gnt=onehot(pick), grant_id=pick, gnt_valid=1, beat_cnt=0.
  - Latch wgt_q = weight[pick]. Go to GRANT.
  - Latency: req rising at posedge t gives gnt visible after posedge t+1 (one cycle).
- State GRANT (granted index g):
  - Beat without release: beat_cnt increments.
  - Release on either event:
    - (a) quota done: a beat occurs while beat_cnt == wgt_q-1.
    - (b) withdraw: req[g]==0.
  - Beat and withdraw in the same cycle: the beat counts as accepted, then release.
  - On release: ptr <= (g+1) mod N, then re-arbitrate in the same cycle using current elig and the new ptr.
    - If any elig: load the new grant back-to-back (no idle bubble), beat_cnt=0, latch a new wgt_q, stay in GRANT.
    - Otherwise go to IDLE and clear gnt, gnt_valid and grant_id.
  - Requester g may be re-granted immediately only if no other requester is eligible; it has lowest priority after ptr moves.
- Weight changes:
  - Changes while in GRANT do not affect the current burst (wgt_q is latched).
  - A weight field set to 0 for g mid-burst does not release the burst.
- beat_cnt never exceeds wgt_q-1 while gnt_valid=1.
- Width rules:
  - Weight max 2^WGT_W-1 beats per burst.
  - ptr wraps N-1 to 0; for non-power-of-2 N, indices >= N are never produced.
- Invariants:
  - gnt is one-hot when gnt_valid=1 and all-zero otherwise.
  - grant_id always matches gnt.
- Reset mid-burst: all outputs clear immediately (asynchronous); ptr returns to 0.

Decomposition:
- Package wrr_arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT};
  - default N/WGT_W constants;
  - a onehot-to-index helper function.
- Sub-module rr_prio_pick: combinational circular priority picker.
  - Inputs: elig[N], ptr.
  - Outputs: any, idx[ID_W].
  - Built by double-width masking; instantiated once.
- Top holds the FSM, ptr, wgt_q, beat counter and output registers.

Test Plan:
1. Reset then single requester: reset low 2 cycles, req=4'b0100, weight2=3, res_ready=1 -> gnt=4'b0100 one cycle after req; beat_cnt 0,1,2; back-to-back re-grant to 2 with beat_cnt=0 (only eligible requester).
2. Rotation: req=4'b1111, all weights=2, res_ready=1 -> grant order 0,0,1,1,2,2,3,3,0 with no idle cycles between bursts.
3. Backpressure and withdraw: grant to 1, weight1=4, res_ready toggles 1,0,1 -> beat_cnt 1 then 2; req[1] drops together with a beat -> beat_cnt 3 counted, then release to next eligible requester, ptr=2.
4. Masking and wrap: req=4'b1001, weight0=0, weight3=1 -> only requester 3 granted repeatedly; then weight0=1 -> alternates 3,0,3,0.
5. Mid-burst weight change and async reset: grant 2 with weight2=5, change weight2 to 1 after beat 1 -> burst still runs 5 beats; assert reset low mid-burst -> gnt=0, gnt_valid=0 immediately (asynchronously, not waiting for a clock edge); next grant picks from ptr=0.
6. Assertions bound to the block:
   - gnt is one-hot or zero;
   - gnt_valid == |gnt;
   - beat_cnt < wgt_q while valid;
   - no grant to a weight-0 requester;
   - each eligible requester is granted within N bursts.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// Shared types, default sizes and helpers for the weighted round-robin burst arbiter.
package wrr_arb_pkg;

   localparam int N_DEF     = 4;
   localparam int WGT_W_DEF = 4;
   localparam int MAX_N     = 16;

   typedef enum logic {IDLE, GRANT} arb_state_e;

   // OR of the indices of all set bits: exact for a one-hot or all-zero input.
   function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Circular priority picker: lowest-index set bit of elig at or after ptr, wrapping to 0.
module rr_prio_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    elig,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] idx
);

   logic [N-1:0]   lo_mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] masked;

   // Lower copy keeps only bits at or above ptr; the upper copy supplies the wrap-around.
   assign lo_mask = ~((N'(1) << ptr) - N'(1));
   assign dbl     = {elig, elig};
   assign masked  = dbl & {{N{1'b1}}, lo_mask};
   assign any     = |elig;

   // NOTE: combinational outputs get a default before the loop so no latch is inferred.
   always_comb begin
      idx = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (masked[i]) idx = (i >= N) ? ID_W'(i - N) : ID_W'(i);
      end
   end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: holds each grant for up to weight[i] accepted beats,
// then rotates priority past the served requester.
module wrr_burst_arbiter
   import wrr_arb_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int WGT_W = WGT_W_DEF,
   parameter int ID_W  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req,
   input  logic [N*WGT_W-1:0] weight,
   input  logic               res_ready,
   output logic [N-1:0]       gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic [WGT_W-1:0]   beat_cnt
);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [WGT_W-1:0]  wgt_q, wgt_d;
   logic [WGT_W-1:0]  beat_q, beat_d;

   logic [N-1:0]      elig;
   logic [ID_W-1:0]   g_idx, g_next, pick_ptr, pick_idx;
   logic [WGT_W-1:0]  pick_wgt;
   logic              pick_any, beat, quota_done, withdraw, rel_burst;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         elig[i] = req[i] && (weight[i*WGT_W +: WGT_W] != '0);
      end
   end

   assign g_idx  = ID_W'(onehot_to_idx(MAX_N'(gnt_q)));
   assign g_next = (g_idx == ID_W'(N-1)) ? '0 : g_idx + ID_W'(1);

   // On release the search starts just past the current grantee, so it becomes lowest priority.
   assign pick_ptr = (state_q == GRANT) ? g_next : ptr_q;

   rr_prio_pick #(.N(N), .ID_W(ID_W)) u_pick (
      .elig (elig),
      .ptr  (pick_ptr),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign pick_wgt   = weight[int'(pick_idx)*WGT_W +: WGT_W];
   assign beat       = (state_q == GRANT) && res_ready;
   assign quota_done = beat && (beat_q == wgt_q - WGT_W'(1));
   assign withdraw   = (state_q == GRANT) && !(|(req & gnt_q));
   assign rel_burst  = quota_done || withdraw;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      wgt_d   = wgt_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               gnt_d   = N'(1) << pick_idx;
               wgt_d   = pick_wgt;
               beat_d  = '0;
            end
         end
         GRANT: begin
            if (rel_burst) begin
               ptr_d  = g_next;
               beat_d = '0;
               if (pick_any) begin
                  gnt_d = N'(1) << pick_idx;
                  wgt_d = pick_wgt;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (beat) begin
               beat_d = beat_q + WGT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments; reset is asynchronous so outputs clear without a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         wgt_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wgt_q   <= wgt_d;
         beat_q  <= beat_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == GRANT);
   assign grant_id  = g_idx;
   assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: directed scenarios plus random traffic,
// compared against a burst-level reference model of the arbitration rules.
module tb_wrr_burst_arbiter;

   localparam int N     = 4;
   localparam int WGT_W = 4;
   localparam int ID_W  = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [N-1:0]       req;
   logic [N*WGT_W-1:0] weight;
   logic               res_ready;
   logic [N-1:0]       gnt;
   logic               gnt_valid;
   logic [ID_W-1:0]    grant_id;
   logic [WGT_W-1:0]   beat_cnt;

   wrr_burst_arbiter #(.N(N), .WGT_W(WGT_W), .ID_W(ID_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .weight    (weight),
      .res_ready (res_ready),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .grant_id  (grant_id),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: who holds the resource, beats taken, burst quota, rotation pointer.
   bit m_valid;
   int m_g, m_beats, m_quota, m_ptr;

   // Values seen at the clock edge just taken, for starvation and weight-0 checks.
   logic [N-1:0]       elig_edge;
   logic [N*WGT_W-1:0] wgt_edge;
   bit                 prev_valid;
   int                 prev_id, prev_beat;
   int                 starve[N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wf(input logic [N*WGT_W-1:0] w, input int i);
      return int'(w[i*WGT_W +: WGT_W]);
   endfunction

   function automatic int pick(input int p);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (req[j] && wf(weight, j) != 0) return j;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_g = 0; m_beats = 0; m_quota = 0; m_ptr = 0;
      prev_valid = 0; prev_id = 0; prev_beat = 0;
      for (int i = 0; i < N; i++) starve[i] = 0;
   endtask

   task automatic model_edge();
      int  j;
      bit  acc, rel;
      if (!m_valid) begin
         j = pick(m_ptr);
         if (j >= 0) begin
            m_valid = 1; m_g = j; m_beats = 0; m_quota = wf(weight, j);
         end
      end else begin
         acc = res_ready;
         rel = !req[m_g] || (acc && (m_beats + 1 == m_quota));
         if (rel) begin
            m_ptr   = (m_g + 1) % N;
            m_beats = 0;
            j = pick(m_ptr);
            if (j >= 0) begin
               m_g = j; m_quota = wf(weight, j);
            end else begin
               m_valid = 0;
            end
         end else if (acc) begin
            m_beats++;
         end
      end
   endtask

   task automatic compare(input string tag);
      bit start;
      int id;
      check({tag, "_gnt"},   32'(gnt),       m_valid ? (32'd1 << m_g) : 32'd0);
      check({tag, "_valid"}, 32'(gnt_valid), 32'(m_valid));
      check({tag, "_id"},    32'(grant_id),  m_valid ? 32'(m_g) : 32'd0);
      check({tag, "_beat"},  32'(beat_cnt),  m_valid ? 32'(m_beats) : 32'd0);
      check({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
      check({tag, "_vld_or"}, 32'(gnt_valid), 32'(|gnt));
      if (m_valid) check({tag, "_beat_lt_q"}, 32'(int'(beat_cnt) < m_quota), 32'd1);
      id    = int'(grant_id);
      start = gnt_valid && beat_cnt == '0 &&
              (!prev_valid || prev_id != id || prev_beat != 0);
      if (start) check({tag, "_w0_grant"}, 32'(wf(wgt_edge, id) != 0), 32'd1);
      for (int i = 0; i < N; i++) begin
         if (!elig_edge[i] || (start && id == i)) starve[i] = 0;
         else if (start) begin
            starve[i]++;
            check($sformatf("%s_starve%0d", tag, i), 32'(starve[i] <= N), 32'd1);
         end
      end
      prev_valid = gnt_valid;
      prev_id    = id;
      prev_beat  = int'(beat_cnt);
   endtask

   task automatic step(input string tag);
      for (int i = 0; i < N; i++) elig_edge[i] = req[i] && wf(weight, i) != 0;
      wgt_edge = weight;
      model_edge();
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      compare("rst");
      reset = 1'b1;
   endtask

   int exp_rot[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   int exp_beat1[4] = '{0, 1, 2, 0};
   int exp_wrap[4] = '{0, 3, 0, 3};
   int exp_beat5[7] = '{0, 1, 2, 3, 4, 0, 0};

   initial begin
      reset     = 1'b0;
      req       = '0;
      weight    = '0;
      res_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      compare("reset");
      reset = 1'b1;

      // Single requester 2, quota 3, always ready
      req = 4'b0100; weight = 16'h0300; res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step("p1");
         check($sformatf("p1_gnt%0d", k), 32'(gnt), 32'h4);
         check($sformatf("p1_beat%0d", k), 32'(beat_cnt), 32'(exp_beat1[k]));
      end

      // Full rotation, quota 2 each, no idle cycles between bursts
      do_reset();
      req = 4'b1111; weight = 16'h2222; res_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step("p2");
         check($sformatf("p2_id%0d", k), 32'(grant_id), 32'(exp_rot[k]));
         check($sformatf("p2_vld%0d", k), 32'(gnt_valid), 32'd1);
      end

      // Backpressure, then withdraw together with a beat
      do_reset();
      req = 4'b0010; weight = 16'h0040; res_ready = 1'b1;
      step("p3");
      check("p3_load", 32'(grant_id), 32'd1);
      res_ready = 1'b1; step("p3"); check("p3_b1", 32'(beat_cnt), 32'd1);
      res_ready = 1'b0; step("p3"); check("p3_hold", 32'(beat_cnt), 32'd1);
      res_ready = 1'b1; step("p3"); check("p3_b2", 32'(beat_cnt), 32'd2);
      req = 4'b0101; weight = 16'h0141; res_ready = 1'b1;
      step("p3");
      check("p3_next_after_ptr", 32'(grant_id), 32'd2);
      check("p3_next_beat", 32'(beat_cnt), 32'd0);

      // Weight-0 masking and pointer wrap
      do_reset();
      req = 4'b1001; weight = 16'h1000; res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step("p4");
         check($sformatf("p4_only3_%0d", k), 32'(grant_id), 32'd3);
      end
      weight = 16'h1001;
      for (int k = 0; k < 4; k++) begin
         step("p4");
         check($sformatf("p4_alt%0d", k), 32'(grant_id), 32'(exp_wrap[k]));
      end

      // Mid-burst weight change does not shorten the burst
      do_reset();
      req = 4'b0100; weight = 16'h0500; res_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) weight = 16'h0100;
         step("p5");
         check($sformatf("p5_beat%0d", k), 32'(beat_cnt), 32'(exp_beat5[k]));
      end

      // Asynchronous reset mid-burst: outputs clear before any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("p5_async_gnt", 32'(gnt), 32'd0);
      check("p5_async_vld", 32'(gnt_valid), 32'd0);
      check("p5_async_beat", 32'(beat_cnt), 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
      req = 4'b1111; weight = 16'h1111;
      step("p5");
      check("p5_ptr0", 32'(grant_id), 32'd0);

      // Random traffic against the reference model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         if ($urandom_range(0, 15) == 0)
            weight[$urandom_range(0, N-1)*WGT_W +: WGT_W] = 4'($urandom_range(0, 3));
         res_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
